psum_out_fifo: RTL and testbench
================================

Name: psum_out_fifo

Overview:
- Receiving end of the systolic row output interface: captures per-column partial sums (out_s) strobed by the per-column valid bits that the MAC rows emit.
- Columns arrive skewed by one cycle per column, so each column has its own FIFO lane.
- A full output row is presented only when every lane holds at least one word. All lanes are then popped together, so the downstream SRAM writer sees column-aligned rows.

Parameters:
- col, 8, number of columns/lanes
- psum_bw, 16, width of one partial sum
- depth, 16, entries per lane (power of 2, >=2)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in  input  psum_bw*col  column i data on bits [psum_bw*i +: psum_bw]
- wr  input  col  per-column write strobe (driven from array valid)
- rd  input  1  pop one aligned row
- out  output  psum_bw*col  head word of each lane, column i in the same slice as in
- o_valid  output  1  all lanes non-empty
- o_full  output  1  any lane full
- o_ready  output  1  no lane full (~o_full)
- o_overflow  output  1  sticky: a write was dropped

Behaviour:
- Reset (synchronous, on clk rising edge with reset=1):
  - all read/write pointers and per-lane counts go to 0, and o_overflow goes to 0.
  - Outputs after reset: o_valid=0, o_full=0, o_ready=1, out=0.
  - Reset overrides any wr/rd in the same cycle.
  - Reset mid-operation discards all buffered data.
- Storage: col independent circular buffers, each depth x psum_bw.
  - Storage arrays are not reset.
  - Per lane: wptr and rptr of width log2(depth), which wrap modulo depth; count of width log2(depth)+1, range 0..depth.
- Write, lane i:
  - When wr[i]=1 and the lane is not full (or a pop happens this cycle, see simultaneity), store in slice i at wptr[i], then increment wptr[i] next cycle.
  - Lanes are written independently; any subset of wr may be high.
- Drop:
  - wr[i]=1 with count[i]==depth and no pop this cycle: the word is discarded, that lane's pointers and count are unchanged, and o_overflow is set to 1 from the next cycle until reset.
- Pop:
  - rd=1 while o_valid=1 increments every rptr and decrements every count by 1 in the same edge.
  - rd=1 while o_valid=0 is ignored; no state changes.
- Simultaneity: pop and write on the same lane in the same cycle are both accepted.
  - The count is unchanged.
  - A full lane accepts the write because the pop frees an entry.
  - If the lane was empty, no pop occurs, since o_valid=0 in that case.
- Output timing:
  - out is first-word-fall-through: combinational from storage at rptr, gated to 0 when o_valid=0.
  - A word written at edge N is visible at out, and counted in o_valid, after edge N (1-cycle write-to-valid latency).
- Flags:
  - o_valid = AND over lanes of (count!=0).
  - o_full = OR over lanes of (count==depth).
  - All flags are derived from registered counts only; there is no combinational path from wr/rd to any output.
- Upstream is expected to stall on o_ready=0; o_overflow is the only indication of protocol violation.

Test Plan:
- Reset, then idle:
  - o_valid=0, o_full=0, o_ready=1, o_overflow=0, out=0.
- Skewed fill:
  - At cycle k, assert wr[k] only for k=0..7, with lane i data = 16'h0100+i.
  - o_valid stays 0 until the edge that writes lane 7; then out = {16'h0107,...,16'h0100}.
  - Pulse rd once -> o_valid=0, out=0.
- Fill to full:
  - Write all lanes 16 times with data = entry index.
  - After the 16th write -> o_full=1, o_ready=0.
  - A 17th write (value 16'hDEAD) -> dropped, o_overflow=1.
  - 16 pops return 0..15 in order on every lane, then o_valid=0; o_overflow stays 1.
- Simultaneous read/write at full:
  - With all lanes full, assert wr=8'hFF with data 16'h00AA and rd=1 in one cycle.
  - Response: counts stay 16, o_overflow stays 0, the head advances to entry 1, and 16'h00AA appears as the 16th pop.
- Wrap-around:
  - Interleave writes and pops for 40 rows, occupancy kept at 3, with lane i data = row*8+i.
  - Every popped row matches in order, and pointers wrap without error.
- Reset mid-operation:
  - With 5 rows buffered, assert reset with rd=1 and wr=8'hFF.
  - Next cycle: o_valid=0, all counts 0, o_overflow=0.
  - A subsequent single full-row write is the only data returned.

Source files
------------

// File: rtl/psum_out_fifo.sv
// Per-column partial-sum capture FIFOs; rows are released column-aligned once every lane holds a word.
// Write-to-out latency 1 cycle (first-word-fall-through); backpressure via o_ready, writes to a full lane are dropped and flagged sticky.

module psum_lane_fifo #(
    parameter int width = 16,
    parameter int depth = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_dat,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             nonempty,
    output logic             full,
    output logic             drop
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_cnt = (aw+1)'(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wptr;
    logic [aw-1:0]    rptr;
    logic [aw:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign nonempty = (cnt != '0);
    assign full     = (cnt == full_cnt);
    assign pop_ok   = pop && nonempty;
    // A pop in the same cycle frees the slot a full lane needs for this write.
    assign push_ok  = push && (!full || pop_ok);
    assign drop     = push && !push_ok;
    assign head     = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + aw'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + aw'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (aw+1)'(1);
                2'b01:   cnt <= cnt - (aw+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module psum_out_fifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);
    logic [psum_bw-1:0] head [col];
    logic [col-1:0]     lane_nonempty;
    logic [col-1:0]     lane_full;
    logic [col-1:0]     lane_drop;
    logic               pop;
    logic               overflow_q;

    // All lanes pop together so the downstream writer always sees aligned rows.
    assign pop = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_lane
        psum_lane_fifo #(
            .width (psum_bw),
            .depth (depth)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .push     (wr[i]),
            .push_dat (in[psum_bw*i +: psum_bw]),
            .pop      (pop),
            .head     (head[i]),
            .nonempty (lane_nonempty[i]),
            .full     (lane_full[i]),
            .drop     (lane_drop[i])
        );

        assign out[psum_bw*i +: psum_bw] = o_valid ? head[i] : '0;
    end

    assign o_valid    = &lane_nonempty;
    assign o_full     = |lane_full;
    assign o_ready    = ~o_full;
    assign o_overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (|lane_drop) begin
            overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psum_out_fifo.sv
// Directed and randomized bench for psum_out_fifo against a queue-based row model.

module tb_psum_out_fifo;
    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [BW*COL-1:0] in;
    logic [COL-1:0]    wr;
    logic              rd;
    logic [BW*COL-1:0] out;
    logic              o_valid, o_full, o_ready, o_overflow;

    int passed = 0;
    int total  = 0;

    logic [BW-1:0] q [COL][$];
    logic          m_ovf = 1'b0;

    psum_out_fifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .wr         (wr),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW*COL-1:0] obs, input logic [BW*COL-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic m_valid();
        for (int i = 0; i < COL; i++)
            if (q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < COL; i++)
            if (q[i].size() == DEP) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [BW*COL-1:0] m_out();
        logic [BW*COL-1:0] v = '0;
        if (m_valid())
            for (int i = 0; i < COL; i++) v[BW*i +: BW] = q[i][0];
        return v;
    endfunction

    // Row-level semantics: a pop removes one word per lane, a write lands unless the lane stays full.
    task automatic model_edge(input logic rst, input logic [COL-1:0] w, input logic [BW*COL-1:0] d, input logic r);
        logic popping;
        if (rst) begin
            for (int i = 0; i < COL; i++) q[i].delete();
            m_ovf = 1'b0;
            return;
        end
        popping = r && m_valid();
        for (int i = 0; i < COL; i++) begin
            if (popping) void'(q[i].pop_front());
            if (w[i]) begin
                if (q[i].size() < DEP) q[i].push_back(d[BW*i +: BW]);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [COL-1:0] w, input logic [BW*COL-1:0] d, input logic r);
        reset = rst; wr = w; in = d; rd = r;
        @(posedge clk);
        model_edge(rst, w, d, r);
        #1;
        reset = 1'b0; wr = '0; rd = 1'b0;
        chk("out",        out,               m_out());
        chk("o_valid",    {127'b0, o_valid},    {127'b0, m_valid()});
        chk("o_full",     {127'b0, o_full},     {127'b0, m_full()});
        chk("o_ready",    {127'b0, o_ready},    {127'b0, ~m_full()});
        chk("o_overflow", {127'b0, o_overflow}, {127'b0, m_ovf});
    endtask

    function automatic logic [BW*COL-1:0] row(input int base, input int stride);
        logic [BW*COL-1:0] v;
        for (int i = 0; i < COL; i++) v[BW*i +: BW] = BW'(base + stride*i);
        return v;
    endfunction

    initial begin
        logic [BW*COL-1:0] d;
        reset = 1'b0; wr = '0; rd = 1'b0; in = '0;

        // Reset then idle
        step(1'b1, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        chk("idle_out", out, '0);
        chk("idle_ready", {127'b0, o_ready}, 128'd1);

        // Skewed fill: lane k written at cycle k
        for (int k = 0; k < COL; k++) begin
            step(1'b0, COL'(1) << k, row(16'h0100, 1), 1'b0);
            if (k < COL-1) chk("skew_not_valid", {127'b0, o_valid}, 128'd0);
        end
        chk("skew_row", out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
        step(1'b0, '0, '0, 1'b1);
        chk("skew_popped", out, '0);

        // Fill to full, overflow, drain
        for (int j = 0; j < DEP; j++) step(1'b0, '1, row(j, 0), 1'b0);
        chk("full_flag", {127'b0, o_full}, 128'd1);
        chk("full_ready", {127'b0, o_ready}, 128'd0);
        step(1'b0, '1, row(16'hDEAD, 0), 1'b0);
        chk("overflow_set", {127'b0, o_overflow}, 128'd1);
        for (int j = 0; j < DEP; j++) begin
            chk("drain_order", out, row(j, 0));
            step(1'b0, '0, '0, 1'b1);
        end
        chk("drain_empty", {127'b0, o_valid}, 128'd0);
        chk("overflow_sticky", {127'b0, o_overflow}, 128'd1);

        // Simultaneous read/write at full
        step(1'b1, '0, '0, 1'b0);
        for (int j = 0; j < DEP; j++) step(1'b0, '1, row(j, 0), 1'b0);
        step(1'b0, '1, row(16'h00AA, 0), 1'b1);
        chk("rw_full_ovf", {127'b0, o_overflow}, 128'd0);
        chk("rw_full_flag", {127'b0, o_full}, 128'd1);
        chk("rw_head", out, row(1, 0));
        for (int j = 0; j < DEP-1; j++) step(1'b0, '0, '0, 1'b1);
        chk("rw_last", out, row(16'h00AA, 0));
        step(1'b0, '0, '0, 1'b1);

        // Wrap-around with occupancy 3
        for (int r = 0; r < 3; r++) step(1'b0, '1, row(r*8, 1), 1'b0);
        for (int r = 3; r < 43; r++) begin
            chk("wrap_head", out, row((r-3)*8, 1));
            step(1'b0, '1, row(r*8, 1), 1'b1);
        end
        for (int r = 40; r < 43; r++) begin
            chk("wrap_tail", out, row(r*8, 1));
            step(1'b0, '0, '0, 1'b1);
        end

        // Reset mid-operation
        for (int r = 0; r < 5; r++) step(1'b0, '1, row(r+16'h0500, 0), 1'b0);
        step(1'b1, '1, row(16'h0BAD, 0), 1'b1);
        chk("mid_rst_valid", {127'b0, o_valid}, 128'd0);
        chk("mid_rst_ovf", {127'b0, o_overflow}, 128'd0);
        step(1'b0, '1, row(16'h0777, 1), 1'b0);
        chk("post_rst_row", out, row(16'h0777, 1));
        step(1'b0, '0, '0, 1'b1);
        chk("post_rst_empty", {127'b0, o_valid}, 128'd0);

        // Randomized traffic, including skewed lanes and overflow
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < COL; i++) d[BW*i +: BW] = BW'($urandom);
            step(($urandom_range(0, 99) == 0), COL'($urandom), d, $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
